contador_programable_ud: RTL and testbench

Programmable up/down modulo counter for the clock/timebase datapath. It extends the fixed/variable-terminal counter with:
- up/down direction;
- a shadow terminal register applied only at sequence boundaries (glitch-free modulus change);
- synchronous load;
- one-shot mode with a done flag;
- a cascade carry for chaining stages (seconds → minutes → hours).

---
 rtl/contador_programable_ud.sv | 135 +++++++++++++
 tb/tb_contador_programable_ud.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_programable_ud.sv
// Programmable up/down modulo counter with shadow terminal, synchronous load,
// one-shot mode and a combinational cascade carry for chaining stages.
module contador_programable_ud #(
    parameter int unsigned MAX_MODULO = 16,
    // Bits needed to hold MAX_MODULO-1, never less than one.
    localparam int unsigned WIDTH = (MAX_MODULO < 2) ? 1 : $clog2(MAX_MODULO)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             variable,
    input  logic [WIDTH-1:0] term_in,
    input  logic             term_we,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    input  logic             start,
    output logic [WIDTH-1:0] cuenta,
    output logic             fin_cuenta,
    output logic             carry,
    output logic             done,
    output logic [WIDTH-1:0] active_term
);

    localparam logic [WIDTH-1:0] TERM_MAX = WIDTH'(MAX_MODULO - 1);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_DONE = 1'b1;

    logic             state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_flag_q, pend_flag_d;

    logic [WIDTH-1:0] term_clamped;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] load_limited;
    logic [WIDTH-1:0] t_cur;
    logic [WIDTH-1:0] t_next;
    logic             running;
    logic             advance;
    logic             wrap;
    logic             stop;
    logic             apply;

    // Clamping, current terminal and end-of-sequence detection.
    always_comb begin
        term_clamped = (term_in > TERM_MAX) ? TERM_MAX : term_in;
        load_clamped = (load_val > TERM_MAX) ? TERM_MAX : load_val;
        t_cur        = variable ? active_q : TERM_MAX;
        // ">=" rather than "==" so a count left above T by a variable toggle still ends.
        fin_cuenta   = up_down ? (cuenta_q >= t_cur) : (cuenta_q == '0);
        running      = (state_q == ST_RUN);
        advance      = running & enable & ~load & ~start;
        wrap         = advance & fin_cuenta & ~one_shot;
        stop         = advance & fin_cuenta & one_shot;
        apply        = load | start | wrap;
        carry        = fin_cuenta & enable & running & ~load & ~start;
    end

    // Shadow terminal: staged on term_we, committed only at sequence boundaries.
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (term_we) begin
            pend_d = term_clamped;
        end
        if (apply) begin
            pend_flag_d = 1'b0;
            if (term_we) begin
                // Bypass: a write coinciding with a boundary takes effect immediately.
                active_d = term_clamped;
            end else if (pend_flag_q) begin
                active_d = pend_q;
            end
        end else if (term_we) begin
            pend_flag_d = 1'b1;
        end
        // Wrap, start and load all see the post-apply terminal.
        t_next = variable ? active_d : TERM_MAX;
    end

    // Count next-state with priority load > start > enabled counting.
    always_comb begin
        cuenta_d     = cuenta_q;
        state_d      = state_q;
        done_d       = done_q;
        load_limited = (load_clamped > t_next) ? t_next : load_clamped;
        if (load) begin
            cuenta_d = load_limited;
            state_d  = ST_RUN;
            done_d   = 1'b0;
        end else if (start) begin
            cuenta_d = up_down ? '0 : t_next;
            state_d  = ST_RUN;
            done_d   = 1'b0;
        end else if (wrap) begin
            cuenta_d = up_down ? '0 : t_next;
        end else if (stop) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end else if (advance) begin
            // fin_cuenta is low here, so neither direction can leave 0..T.
            cuenta_d = up_down ? (cuenta_q + 1'b1) : (cuenta_q - 1'b1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            cuenta_q    <= '0;
            active_q    <= TERM_MAX;
            pend_q      <= TERM_MAX;
            pend_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            cuenta_q    <= cuenta_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    assign cuenta      = cuenta_q;
    assign done        = done_q;
    assign active_term = active_q;

endmodule

// File: tb/tb_contador_programable_ud.sv
// Scoreboard bench for contador_programable_ud: two instances (moduli 16 and 10)
// share stimulus; a reference model pushes expectations, a monitor pops and compares.
module tb_contador_programable_ud;

    logic       clock, reset, enable, up_down, variable, term_we, load, one_shot, start;
    logic [3:0] term_in, load_val;
    logic [3:0] cuenta0, active0, cuenta1, active1;
    logic       fin0, carry0, done0, fin1, carry1, done1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int act;
        bit dn;
        bit fin;
        bit cry;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one entry per instance.
    int mm[2] = '{16, 10};
    int m_cnt[2];
    int m_act[2];
    int m_pend[2];
    bit m_pflag[2];
    bit m_done[2];

    contador_programable_ud #(.MAX_MODULO(16)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .variable(variable), .term_in(term_in), .term_we(term_we), .load(load),
        .load_val(load_val), .one_shot(one_shot), .start(start), .cuenta(cuenta0),
        .fin_cuenta(fin0), .carry(carry0), .done(done0), .active_term(active0)
    );

    contador_programable_ud #(.MAX_MODULO(10)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .variable(variable), .term_in(term_in), .term_we(term_we), .load(load),
        .load_val(load_val), .one_shot(one_shot), .start(start), .cuenta(cuenta1),
        .fin_cuenta(fin1), .carry(carry1), .done(done1), .active_term(active1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v > m - 1) ? m - 1 : v;
    endfunction

    task automatic model_reset(input int i);
        m_cnt[i]   = 0;
        m_act[i]   = mm[i] - 1;
        m_pend[i]  = mm[i] - 1;
        m_pflag[i] = 1'b0;
        m_done[i]  = 1'b0;
    endtask

    // Observable outputs for the present state and present inputs.
    task automatic model_eval(input int i, output exp_t e);
        int t;
        t     = variable ? m_act[i] : mm[i] - 1;
        e.cnt = m_cnt[i];
        e.act = m_act[i];
        e.dn  = m_done[i];
        e.fin = up_down ? (m_cnt[i] >= t) : (m_cnt[i] == 0);
        e.cry = e.fin && enable && !m_done[i] && !load && !start;
    endtask

    // State after the coming clock edge.
    task automatic model_advance(input int i);
        int  t, m, tin, lv;
        bit  f, adv, wr, stp;
        m   = mm[i];
        t   = variable ? m_act[i] : m - 1;
        f   = up_down ? (m_cnt[i] >= t) : (m_cnt[i] == 0);
        adv = !m_done[i] && enable && !load && !start;
        wr  = adv && f && !one_shot;
        stp = adv && f && one_shot;
        tin = clampv(int'(term_in), m);
        if (load || start || wr) begin
            if (term_we) begin
                m_act[i]  = tin;
                m_pend[i] = tin;
            end else if (m_pflag[i]) begin
                m_act[i] = m_pend[i];
            end
            m_pflag[i] = 1'b0;
        end else if (term_we) begin
            m_pend[i]  = tin;
            m_pflag[i] = 1'b1;
        end
        t = variable ? m_act[i] : m - 1;
        if (load) begin
            lv        = clampv(int'(load_val), m);
            m_cnt[i]  = (lv < t) ? lv : t;
            m_done[i] = 1'b0;
        end else if (start) begin
            m_cnt[i]  = up_down ? 0 : t;
            m_done[i] = 1'b0;
        end else if (wr) begin
            m_cnt[i] = up_down ? 0 : t;
        end else if (stp) begin
            m_done[i] = 1'b1;
        end else if (adv) begin
            m_cnt[i] = up_down ? m_cnt[i] + 1 : m_cnt[i] - 1;
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, queue expectations.
    task automatic step(input bit r, input bit en, input bit ud, input bit vr, input bit we,
                        input int ti, input bit ld, input int lv, input bit os, input bit st);
        exp_t e;
        reset    = r;
        enable   = en;
        up_down  = ud;
        variable = vr;
        term_we  = we;
        term_in  = ti[3:0];
        load     = ld;
        load_val = lv[3:0];
        one_shot = os;
        start    = st;
        for (int i = 0; i < 2; i++) begin
            if (r) model_reset(i);
            model_eval(i, e);
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
            if (!r) model_advance(i);
        end
        @(negedge clock);
    endtask

    // Monitor: every cycle both instances present outputs; compare against queue heads.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("m16_cuenta", int'(cuenta0), e.cnt);
                chk("m16_active_term", int'(active0), e.act);
                chk("m16_done", int'(done0), int'(e.dn));
                chk("m16_fin_cuenta", int'(fin0), int'(e.fin));
                chk("m16_carry", int'(carry0), int'(e.cry));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("m10_cuenta", int'(cuenta1), e.cnt);
                chk("m10_active_term", int'(active1), e.act);
                chk("m10_done", int'(done1), int'(e.dn));
                chk("m10_fin_cuenta", int'(fin1), int'(e.fin));
                chk("m10_carry", int'(carry1), int'(e.cry));
            end
        end
    end

    initial begin
        bit r_os, r_ud, r_var;
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; variable = 1'b0; term_we = 1'b0;
        term_in = '0; load = 1'b0; load_val = '0; one_shot = 1'b0; start = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("reset_cuenta", int'(cuenta0), 0);
        chk("reset_active_m16", int'(active0), 15);
        chk("reset_active_m10", int'(active1), 9);
        chk("reset_done", int'(done0), 0);
        @(negedge clock);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Default wrap for 20 cycles, then on to cuenta=7 and an asynchronous reset.
        for (int k = 0; k < 23; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("count_at_7", int'(cuenta0), 7);
        reset = 1'b1;
        #1;
        chk("async_reset_cuenta", int'(cuenta0), 0);
        chk("async_reset_active", int'(active0), 15);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Shadow terminal 9 written mid-sequence; 12 clamps on the modulus-10 stage.
        for (int k = 0; k < 4; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 9, 0, 0, 0, 0);
        chk("shadow_held", int'(active0), 15);
        for (int k = 0; k < 24; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 12, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

        // Down count with T=5.
        step(0, 0, 0, 1, 1, 5, 1, 5, 0, 0);
        chk("down_load", int'(cuenta0), 5);
        for (int k = 0; k < 8; k++) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // One-shot with T=3, then restart.
        step(0, 0, 1, 1, 1, 3, 1, 0, 1, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        chk("oneshot_hold", int'(cuenta0), 3);
        chk("oneshot_done", int'(done0), 1);
        step(0, 1, 1, 1, 0, 0, 0, 0, 1, 1);
        chk("restart_cuenta", int'(cuenta0), 0);
        chk("restart_done", int'(done0), 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);

        // Priority and clamp with T=9.
        step(0, 0, 1, 1, 1, 9, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1, 12, 0, 0);
        chk("load_clamp", int'(cuenta0), 9);
        step(0, 1, 1, 1, 0, 0, 1, 7, 0, 1);
        chk("load_priority", int'(cuenta0), 7);
        chk("load_done_clear", int'(done0), 0);

        // term_we coinciding with an up wrap, then with a down wrap.
        step(0, 0, 1, 1, 1, 15, 1, 15, 0, 0);
        step(0, 1, 1, 1, 1, 4, 0, 0, 0, 0);
        chk("bypass_up_cuenta", int'(cuenta0), 0);
        chk("bypass_up_active", int'(active0), 4);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 15, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1, 4, 0, 0, 0, 0);
        chk("bypass_down_cuenta", int'(cuenta0), 4);

        // Randomized phase with slowly varying modes.
        r_os = 0; r_ud = 1; r_var = 1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) r_os = ~r_os;
            if ($urandom_range(0, 9) == 0) r_ud = ~r_ud;
            if ($urandom_range(0, 29) == 0) r_var = ~r_var;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, r_ud, r_var,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 24) == 0, int'($urandom_range(0, 15)), r_os,
                 $urandom_range(0, 24) == 0);
        end

        #5;
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
